// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
// Sweeps a combinational N-input, 1-output block through all 2^N input
// vectors. Each vector is held SETTLE cycles, and the block's output is
// sampled on the last of those cycles. The captured truth table is then
// compared against an expected table that is latched when the sweep starts.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; vec held at 0; results from the last sweep held
//   RUN   | sweep in progress; vec = current index; cnt counts settle cycles
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; overrides every other input
//   start      begin a sweep; only sampled in IDLE
//   abort      cancel a running sweep and clear its results
//   expected   expected truth table; bit i is the output for vector i
//   dut_s      output of the controlled combinational block
//   vec        input vector driven to the block (for N=3: a=vec[2], b=vec[1], c=vec[0])
//   busy       sweep in progress
//   done       one-cycle pulse when a sweep completes
//   pass       captured table matched the expected table
//   table_out  captured truth table
//   err_count  number of mismatching entries
//   first_err  lowest mismatching index, 0 when there is no mismatch
module truth_table_sequencer #(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [(1<<N)-1:0]   expected,
    input  logic                dut_s,
    output logic [N-1:0]        vec,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [(1<<N)-1:0]   table_out,
    output logic [N:0]          err_count,
    output logic [N-1:0]        first_err
);

    localparam int W = 1 << N;
    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};
    localparam logic [3:0]   CNT_LAST = 4'(SETTLE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [W-1:0]   exp_lat;
    logic [3:0]     cnt;
    logic           miss;

    // vec doubles as the sweep index, so the mismatch test uses it directly.
    assign miss = dut_s ^ exp_lat[vec];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            exp_lat   <= '0;
            cnt       <= '0;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            table_out <= '0;
            err_count <= '0;
            first_err <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is meaningless here, so start wins when both are high.
                    if (start) begin
                        exp_lat   <= expected;
                        table_out <= '0;
                        err_count <= '0;
                        first_err <= '0;
                        pass      <= 1'b0;
                        vec       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy      <= 1'b0;
                        vec       <= '0;
                        pass      <= 1'b0;
                        table_out <= '0;
                        err_count <= '0;
                        first_err <= '0;
                        state     <= IDLE;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        table_out[vec] <= dut_s;
                        if (miss) begin
                            err_count <= err_count + (N+1)'(1);
                            if (err_count == '0)
                                first_err <= vec;
                        end
                        if (vec == LAST_IDX) begin
                            // err_count has not yet absorbed this entry's miss.
                            pass  <= (err_count == '0) && !miss;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            vec   <= '0;
                            state <= IDLE;
                        end else begin
                            vec <= vec + N'(1);
                            cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer. Two instances are driven: one
// with SETTLE=1 and one with SETTLE=3. Each controls its own model of the
// nested-mux block s = c ? ~c : (a ? ~a : b), whose truth table is 8'h04.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       reset, start1, start3, abort;
    logic [7:0] expected;

    logic [2:0] vec1, vec3;
    logic       busy1, busy3, done1, done3, pass1, pass3, s1, s3;
    logic [7:0] table1, table3;
    logic [3:0] errc1, errc3;
    logic [2:0] ferr1, ferr3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic mux_block(input logic [2:0] v);
        logic a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        return c ? ~c : (a ? ~a : b);
    endfunction

    assign s1 = mux_block(vec1);
    assign s3 = mux_block(vec3);

    truth_table_sequencer #(.N(3), .SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort),
        .expected(expected), .dut_s(s1), .vec(vec1), .busy(busy1),
        .done(done1), .pass(pass1), .table_out(table1),
        .err_count(errc1), .first_err(ferr1)
    );

    truth_table_sequencer #(.N(3), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort),
        .expected(expected), .dut_s(s3), .vec(vec3), .busy(busy3),
        .done(done3), .pass(pass3), .table_out(table3),
        .err_count(errc3), .first_err(ferr3)
    );

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_results(input string name, input logic [7:0] tbl,
                                 input logic p, input logic [3:0] ec,
                                 input logic [2:0] fe);
        tests++;
        if ({table1, pass1, errc1, ferr1} !== {tbl, p, ec, fe}) begin
            fails++;
            $display("FAIL %s: table=%h pass=%b err=%0d first=%0d, want table=%h pass=%b err=%0d first=%0d",
                     name, table1, pass1, errc1, ferr1, tbl, p, ec, fe);
        end
    endtask

    task automatic check_idle_zero(input string name);
        tests++;
        if ({vec1, busy1, done1, pass1, table1, errc1, ferr1} !== '0) begin
            fails++;
            $display("FAIL %s: vec=%0d busy=%b done=%b pass=%b table=%h err=%0d first=%0d, want all zero",
                     name, vec1, busy1, done1, pass1, table1, errc1, ferr1);
        end
    endtask

    // Pulses start on dut1 and follows the sweep to the done cycle, ending at
    // the negedge where done should be high.
    task automatic run_sweep1(input string name, input logic [7:0] exp_tbl);
        logic vec_ok;
        @(negedge clk);
        expected = exp_tbl;
        start1 = 1'b1;
        cycle();
        start1 = 1'b0;
        vec_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (vec1 !== 3'(k) || busy1 !== 1'b1 || done1 !== 1'b0) vec_ok = 1'b0;
            cycle();
        end
        tests++;
        if (!vec_ok) begin
            fails++;
            $display("FAIL %s_vec_seq: vector sequence or busy wrong, want 0..7 with busy=1", name);
        end
        tests++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || vec1 !== 3'd0) begin
            fails++;
            $display("FAIL %s_done: done=%b busy=%b vec=%0d, want done=1 busy=0 vec=0",
                     name, done1, busy1, vec1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start1 = 1'b0; start3 = 1'b0; abort = 1'b0; expected = 8'hA5;
        repeat (3) cycle();
        reset = 1'b0;
        check_idle_zero("reset_state");
    endtask

    task automatic test_sweep_pass();
        run_sweep1("pass04", 8'h04);
        check_results("pass04_results", 8'h04, 1'b1, 4'd0, 3'd0);
        cycle();
        tests++;
        if (done1 !== 1'b0 || pass1 !== 1'b1 || table1 !== 8'h04) begin
            fails++;
            $display("FAIL done_one_cycle: done=%b pass=%b table=%h, want done=0 pass=1 table=04",
                     done1, pass1, table1);
        end
    endtask

    task automatic test_sweep_one_err();
        run_sweep1("err05", 8'h05);
        check_results("err05_results", 8'h04, 1'b0, 4'd1, 3'd0);
    endtask

    task automatic test_sweep_all_err();
        run_sweep1("errFB", 8'hFB);
        check_results("errFB_results", 8'h04, 1'b0, 4'd8, 3'd0);
    endtask

    task automatic test_expected_latched();
        @(negedge clk);
        expected = 8'h04;
        start1 = 1'b1;
        cycle();
        start1 = 1'b0;
        expected = 8'hFF;
        repeat (8) cycle();
        tests++;
        if (done1 !== 1'b1) begin
            fails++;
            $display("FAIL latch_done: done=%b, want 1", done1);
        end
        check_results("latch_results", 8'h04, 1'b1, 4'd0, 3'd0);
    endtask

    task automatic test_abort_idle();
        // Results of the previous pass sweep must survive abort in IDLE.
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check_results("abort_idle_hold", 8'h04, 1'b1, 4'd0, 3'd0);
        tests++;
        if (busy1 !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle_busy: busy=%b, want 0", busy1);
        end
    endtask

    task automatic test_settle3();
        logic vec_ok;
        @(negedge clk);
        expected = 8'h04;
        start3 = 1'b1;
        cycle();
        start3 = 1'b0;
        vec_ok = 1'b1;
        for (int m = 0; m < 24; m++) begin
            if (vec3 !== 3'(m / 3) || busy3 !== 1'b1 || done3 !== 1'b0) vec_ok = 1'b0;
            cycle();
        end
        tests++;
        if (!vec_ok) begin
            fails++;
            $display("FAIL settle3_vec_seq: each vector must be held 3 cycles with busy=1");
        end
        tests++;
        if (done3 !== 1'b1 || pass3 !== 1'b1 || table3 !== 8'h04 || errc3 !== 4'd0) begin
            fails++;
            $display("FAIL settle3_done: done=%b pass=%b table=%h err=%0d, want done=1 pass=1 table=04 err=0",
                     done3, pass3, table3, errc3);
        end
    endtask

    task automatic test_start_ignored_and_abort();
        logic saw_done;
        @(negedge clk);
        expected = 8'h04;
        start1 = 1'b1;
        cycle();
        start1 = 1'b0;
        repeat (3) cycle();
        start1 = 1'b1;
        cycle();
        start1 = 1'b0;
        tests++;
        if (vec1 !== 3'd4 || busy1 !== 1'b1) begin
            fails++;
            $display("FAIL start_while_busy: vec=%0d busy=%b, want vec=4 busy=1", vec1, busy1);
        end
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check_idle_zero("abort_run");
        saw_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done1 !== 1'b0 || busy1 !== 1'b0) saw_done = 1'b1;
            cycle();
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL abort_no_done: done or busy seen high after abort, want both low");
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic saw_done;
        @(negedge clk);
        expected = 8'h05;
        start1 = 1'b1;
        cycle();
        start1 = 1'b0;
        repeat (5) cycle();
        tests++;
        if (vec1 !== 3'd5) begin
            fails++;
            $display("FAIL reset_mid_setup: vec=%0d, want 5", vec1);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_idle_zero("reset_mid_sweep");
        saw_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done1 !== 1'b0) saw_done = 1'b1;
            cycle();
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL reset_no_done: done pulsed after reset, want no pulse");
        end
    endtask

    task automatic test_back_to_back();
        run_sweep1("b2b_first", 8'h04);
        // Still in the done cycle: start with abort also high, start must win.
        expected = 8'h00;
        start1 = 1'b1;
        abort = 1'b1;
        cycle();
        start1 = 1'b0;
        abort = 1'b0;
        tests++;
        if (busy1 !== 1'b1 || vec1 !== 3'd0 || table1 !== 8'h00 || pass1 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b vec=%0d table=%h pass=%b, want busy=1 vec=0 table=00 pass=0",
                     busy1, vec1, table1, pass1);
        end
        repeat (8) cycle();
        tests++;
        if (done1 !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done: done=%b, want 1", done1);
        end
        check_results("b2b_results", 8'h04, 1'b0, 4'd1, 3'd2);
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start3 = 1'b0; abort = 1'b0; expected = 8'h00;
        test_reset();
        test_sweep_pass();
        test_sweep_one_err();
        test_sweep_all_err();
        test_expected_latched();
        test_abort_idle();
        test_settle3();
        test_start_ignored_and_abort();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Controller that sequences a combinational N-input, 1-output logic block (e.g. the 3-input nested-mux circuits of the Rec02 set) through all 2^N input vectors.
- Captures the block's output into a truth-table register and compares it against an expected table.
- Reports pass/fail, mismatch count and first failing index.
- Sits between a bench or top-level and the combinational datapath under control.

Parameters:
- N, 3, number of datapath inputs; table width is 2^N.
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled only when idle
- abort  input  1  synchronous cancel of a running sweep
- expected  input  2^N  expected truth table; bit i is the output for vector i
- dut_s  input  1  output of the controlled combinational block
- vec  output  N  input vector driven to the block; for N=3, vec[2]=a, vec[1]=b, vec[0]=c
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  table matched expected; valid from done until next start
- table_out  output  2^N  captured truth table
- err_count  output  N+1  number of mismatching entries
- first_err  output  N  lowest mismatching index; 0 when err_count=0

Behaviour:
- Reset (synchronous, active-high; wins over every other input): state IDLE; vec=0, busy=0, done=0, pass=0, table_out=0, err_count=0, first_err=0, expected latch=0.
- States:
  - IDLE: vec=0. start=1 -> latch expected; clear table_out/err_count/first_err/pass; idx=0; cnt=0; busy<=1; go RUN.
  - RUN: vec=idx. Each cycle with cnt<SETTLE-1, cnt++.
  - RUN, cnt==SETTLE-1: table_out[idx]<=dut_s. If dut_s != latched expected[idx], err_count++, and first_err<=idx if this is the first error.
  - RUN, then: if idx==2^N-1 -> busy<=0, done<=1, pass<=(no mismatch including this entry), vec<=0, go IDLE. Else idx++, cnt=0.
- Latency: each vector is held exactly SETTLE cycles. done rises 2^N*SETTLE cycles after the start-accept edge.
- done is high for exactly one cycle. pass, table_out, err_count and first_err hold until the next accepted start or reset.
- The comparison uses the latched expected. Changes on the expected input during RUN are ignored.
- start while busy: ignored, no effect.
- start during the done cycle (state already IDLE): accepted; results are cleared at that edge.
- abort in RUN: at the next edge go IDLE; busy=0, vec=0, done not pulsed, pass=0, table_out=0, err_count=0. abort in IDLE has no effect.
- abort and start in the same IDLE cycle: start is accepted.
- reset mid-sweep: identical to the reset values; no done pulse.
- err_count saturates naturally at 2^N (its width is N+1).
- idx does not wrap inside a sweep. The sweep terminates at 2^N-1.

Test Plan:
- Reset; N=3, SETTLE=1; dut_s = c?~c:(a?~a:b); expected=8'h04; pulse start -> vec steps 0..7, one per cycle. done pulses 8 cycles after the start edge; table_out=8'h04, pass=1, err_count=0, first_err=0.
- Same DUT, expected=8'h05 -> table_out=8'h04, pass=0, err_count=1, first_err=0.
- Same DUT, expected=8'hFB -> pass=0, err_count=8, first_err=0.
- SETTLE=3, expected=8'h04 -> each vec value held 3 cycles; done 24 cycles after start; pass=1.
- Start run; assert start again at vector 3 -> ignored, sweep unchanged. Assert abort at vector 4 -> next cycle busy=0, vec=0, table_out=0, no done pulse. Repeat the run with reset at vector 5 -> all outputs at reset values.
- Complete a sweep; assert start in the done cycle with expected=8'h00 -> new sweep begins immediately; ends with err_count=1, first_err=2, pass=0.
